// File: rtl/dataflow_pipe.sv
// dataflow_pipe: elastic valid/ready register pipeline of STAGES stages.
// Input words are AND-masked on acceptance. Empty stages pull from upstream
// even when the stage below is stalled, so bubbles collapse. A synchronous
// flush drops every in-flight word. Occupancy is kept as a registered count.
module dataflow_pipe #(
    parameter int               WIDTH  = 8,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] MASK   = {WIDTH{1'b1}},
    localparam int              OCC_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Per-stage state: valid bit and data word; stage STAGES-1 is the output.
    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0][WIDTH-1:0] r_d;
    logic [OCC_W-1:0]             r_occ;

    // w_rdy[k]: stage k may take a word this cycle. w_rdy[STAGES] is the consumer.
    logic [STAGES:0]              w_rdy;
    logic [STAGES-1:0]            w_load;
    logic [STAGES-1:0]            w_leave;
    logic [STAGES-1:0][WIDTH-1:0] w_src;
    logic                         w_in_fire;
    logic                         w_out_fire;

    // Ready ripples from the consumer back to the producer: a stage is ready
    // when it is empty or the stage below it is ready.
    always_comb begin
        logic w_acc;
        w_rdy          = '0;
        w_acc          = out_ready;
        w_rdy[STAGES]  = w_acc;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc    = !r_v[k] | w_acc;
            w_rdy[k] = w_acc;
        end
    end

    assign in_ready   = w_rdy[0] & !flush;
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = r_v[STAGES-1] & !flush;
    assign out_data   = r_d[STAGES-1];
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_occ;

    // Per-stage load source and handshake terms.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_load[gi] = w_in_fire;
                assign w_src[gi]  = in_data & MASK;
            end else begin : g_body
                assign w_load[gi] = r_v[gi-1] & w_rdy[gi];
                assign w_src[gi]  = r_d[gi-1];
            end
            // Stage gi hands its word downstream this cycle.
            assign w_leave[gi] = r_v[gi] & w_rdy[gi+1];
        end
    endgenerate

    // Stage registers: reset clears everything, flush clears only valids,
    // otherwise a stage loads from upstream or empties when its word moves on.
    // Data is written only on load, so a stalled stage keeps its word intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_d <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= 1'b1;
                    r_d[k] <= w_src[k];
                end else if (w_leave[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    end

    // Occupancy counter tracks the number of valid stages from the two handshakes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_dataflow_pipe.sv
// tb_dataflow_pipe: directed bench with a scoreboard for dataflow_pipe.
// Two instances share all inputs: A (STAGES=2, MASK=0F) and B (STAGES=1,
// MASK=FF). 'sel' chooses which one the scoreboard observes.
module tb_dataflow_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [1:0] a_occ;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [0:0] b_occ;

    logic       sel;
    logic       obs_ready, obs_valid;
    logic [7:0] obs_data;
    logic [1:0] obs_occ;

    logic [7:0] mask_exp;
    int         stages_exp;
    logic       chk_lat;
    int         cyc;
    int         n_cmp;
    int         n_err;

    logic [7:0] exp_q[$];
    int         cyc_q[$];
    logic [7:0] words[3] = '{8'hA5, 8'h3C, 8'hFF};

    always #5 clk = ~clk;

    dataflow_pipe #(.WIDTH(8), .STAGES(2), .MASK(8'h0F)) u_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    dataflow_pipe #(.WIDTH(8), .STAGES(1), .MASK(8'hFF)) u_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    always_comb begin
        obs_ready = sel ? b_in_ready  : a_in_ready;
        obs_valid = sel ? b_out_valid : a_out_valid;
        obs_data  = sel ? b_out_data  : a_out_data;
        obs_occ   = sel ? {1'b0, b_occ} : a_occ;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update scoreboard, advance.
    task automatic cycle();
        logic       r, v;
        logic [7:0] d, e;
        int         c;
        #1;
        r = obs_ready;
        v = obs_valid;
        d = obs_data;
        if (!rst && !flush && in_valid && r) begin
            exp_q.push_back(in_data & mask_exp);
            cyc_q.push_back(cyc);
            $display("xfer in  %h", in_data);
        end
        if (!rst && v && out_ready) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL out_unexpected observed=%h expected=none", d);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("out_data", d, e);
                if (chk_lat) chk("latency", cyc - c, stages_exp);
                $display("xfer out %h", d);
            end
        end
        if (rst || flush) begin
            exp_q.delete();
            cyc_q.delete();
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
        #1;
        chk("drain_occ", obs_occ, 0);
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data",  a_out_data, 0);
        chk("rst_a_occ",       a_occ, 0);
        chk("rst_a_in_ready",  a_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_data",  b_out_data, 0);
        chk("rst_b_occ",       b_occ, 0);
        chk("rst_b_in_ready",  b_in_ready, 1);
    endtask

    task automatic run_stream();
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            #1;
            chk("st_in_ready", obs_ready, 1);
            cycle();
        end
        drain();
        chk_lat = 1'b0;
    endtask

    task automatic run_bp();
        int   nxt;
        logic acc;
        out_ready = 1'b0;
        for (int i = 0; i <= stages_exp; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            #1;
            chk("bp_in_ready", obs_ready, (i < stages_exp) ? 1 : 0);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_occ",       obs_occ, stages_exp);
            chk("bp_out_valid", obs_valid, 1);
            chk("bp_hold_data", obs_data, 8'h01);
            chk("bp_stalled",   obs_ready, 0);
            cycle();
        end
        out_ready = 1'b1;
        nxt = stages_exp + 1;
        for (int i = 0; i < 20 && nxt <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(nxt);
            #1;
            acc = obs_ready;
            cycle();
            if (acc) nxt++;
        end
        chk("bp_all_sent", nxt, 4);
        drain();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        sel = 1'b0; mask_exp = 8'h0F; stages_exp = 2; chk_lat = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;

        // Reset with a word offered: nothing may be accepted.
        cycle();
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        reset_checks();

        // Streaming, then backpressure on the two-stage masked pipe.
        run_stream();
        run_bp();

        // Bubble collapse: only the output stage valid, downstream stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h1A;
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        chk("bub_occ1",      obs_occ, 1);
        chk("bub_out_valid", obs_valid, 1);
        in_valid = 1'b1; in_data = 8'h07;
        #1;
        chk("bub_in_ready", obs_ready, 1);
        cycle();
        #1;
        chk("bub_occ2", obs_occ, 2);
        // Full with consumer ready: simultaneous in and out.
        out_ready = 1'b1; in_data = 8'h2B;
        #1;
        chk("full_in_ready", obs_ready, 1);
        cycle();
        #1;
        chk("full_occ", obs_occ, 2);
        drain();

        // Flush with two words in flight and a word offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h31;
        cycle();
        in_data = 8'h32;
        cycle();
        #1;
        chk("fl_occ_before", obs_occ, 2);
        flush = 1'b1; in_data = 8'h99;
        #1;
        chk("fl_in_ready",  obs_ready, 0);
        chk("fl_out_valid", obs_valid, 0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_occ_after",   obs_occ, 0);
        chk("fl_valid_after", obs_valid, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h4E;
        cycle();
        drain();
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-stream with the pipe full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h61;
        cycle();
        in_data = 8'h62;
        cycle();
        #1;
        chk("rm_occ_before", obs_occ, 2);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        reset_checks();

        // Single-stage, unmasked instance.
        sel = 1'b1; mask_exp = 8'hFF; stages_exp = 1;
        run_stream();
        run_bp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
